// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension multiply/divide unit with valid/ready handshakes, flush and tag passthrough.
// Optional MULDIV_WORD_OPS_EN enables the RV64 W variants (MULW/DIVW/DIVUW/REMW/REMUW).
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int XLEN        = 64,
  parameter int MUL_LATENCY = 4,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CW = 7;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  typedef struct packed {
    logic [1:0]       fn;
    logic             word;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
  } req_t;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r       = '0;
    r[31:0] = v[31:0];
    return r;
  endfunction

  state_t          state_q, state_d;
  req_t            req_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvsr_q, result_q;
  logic            neg_q_q, neg_r_q;
  logic            accept;

  // accept-time decode of the divide operands and special cases
  logic            in_div, in_sgn, in_wrd, a_neg, b_neg, in_spec;
  logic [XLEN-1:0] a_eff, b_eff, a_abs, b_abs, min_val, spec_q, spec_r;

  always_comb begin
    in_div = op_i[2];
    in_sgn = op_i[2] & ~op_i[0];
`ifdef MULDIV_WORD_OPS_EN
    in_wrd = word_i & ((op_i == 3'd0) | op_i[2]);
`else
    in_wrd = word_i & 1'b0;
`endif
    a_eff   = in_wrd ? (in_sgn ? sext32(op_a_i) : zext32(op_a_i)) : op_a_i;
    b_eff   = in_wrd ? (in_sgn ? sext32(op_b_i) : zext32(op_b_i)) : op_b_i;
    a_neg   = in_sgn & a_eff[XLEN-1];
    b_neg   = in_sgn & b_eff[XLEN-1];
    a_abs   = a_neg ? -a_eff : a_eff;
    b_abs   = b_neg ? -b_eff : b_eff;
    min_val = in_wrd ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    spec_q  = '1;
    spec_r  = a_eff;
    in_spec = 1'b0;
    if (b_eff == '0) begin
      in_spec = 1'b1;
    end else if (in_sgn && (&b_eff) && (a_eff == min_val)) begin
      in_spec = 1'b1;
      spec_q  = a_eff;
      spec_r  = '0;
    end
  end

  // single wide product; operand extension selects MULH/MULHSU/MULHU
  logic              a_s, b_s;
  logic [2*XLEN-1:0] a_x, b_x, prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    a_s  = req_q.fn != 2'd3;
    b_s  = ~req_q.fn[1];
    a_x  = {{XLEN{a_s & req_q.a[XLEN-1]}}, req_q.a};
    b_x  = {{XLEN{b_s & req_q.b[XLEN-1]}}, req_q.b};
    prod = a_x * b_x;
    if (req_q.fn == 2'd0) mul_res = req_q.word ? sext32(prod[XLEN-1:0]) : prod[XLEN-1:0];
    else                  mul_res = prod[2*XLEN-1:XLEN];
  end

  // restoring divider step: dividend bits shift out of quo_q into rem_q
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] quo_nx, rem_nx, q_fix, r_fix, f_sel, fix_res;

  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvsr_q};
    ge      = ~diff[XLEN];
    rem_nx  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ge};
    q_fix   = neg_q_q ? -quo_q : quo_q;
    r_fix   = neg_r_q ? -rem_q : rem_q;
    f_sel   = req_q.fn[1] ? r_fix : q_fix;
    fix_res = req_q.word ? sext32(f_sel) : f_sel;
  end

  assign accept = (state_q == IDLE) & valid_i & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (valid_i) state_d = in_div ? (in_spec ? FIX : DIV) : MUL;
        MUL:  if (cnt_q == '0) state_d = DONE;
        DIV:  if (cnt_q == '0) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        req_q <= '{fn: op_i[1:0], word: in_wrd, a: op_a_i, b: op_b_i, tag: tag_i};
        cnt_q <= in_div ? (in_wrd ? CW'(31) : CW'(XLEN-1)) : CW'(MUL_LATENCY-1);
        if (in_spec) begin
          quo_q   <= spec_q;
          rem_q   <= spec_r;
          neg_q_q <= 1'b0;
          neg_r_q <= 1'b0;
        end else begin
          // W divides keep the 32-bit dividend at the top so 32 steps suffice
          quo_q   <= in_wrd ? (a_abs << (XLEN-32)) : a_abs;
          rem_q   <= '0;
          neg_q_q <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
        end
        dvsr_q <= b_abs;
      end
      if ((state_q == MUL || state_q == DIV) && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (state_q == DIV) begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
      end
      if (state_d == DONE && state_q == MUL) result_q <= mul_res;
      if (state_d == DONE && state_q == FIX) result_q <= fix_res;
    end
  end

  assign ready_o  = state_q == IDLE;
  assign valid_o  = state_q == DONE;
  assign result_o = result_q;
  assign tag_o    = req_q.tag;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=64, MUL_LATENCY=4, TAG_W=5).
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int XLEN = 64;
  localparam int TW   = 5;

  logic            clk, rst_n, valid_i, ready_o, word_i, flush_i, valid_o, ready_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] op_a_i, op_b_i, result_o;
  logic [TW-1:0]   tag_i, tag_o;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(4), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .word_i(word_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .tag_i(tag_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // drive request, accept on the next edge (edge 0), then scramble inputs
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] t);
    op_i = op; word_i = w; op_a_i = a; op_b_i = b; tag_i = t; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; op_i = 3'd7 - op; op_a_i = ~a; op_b_i = ~b; tag_i = ~t; word_i = ~w;
  endtask

  task automatic wait_done(output int lat, output int rdy_hi);
    lat = 0; rdy_hi = 0;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (ready_o) rdy_hi++;
    end
  endtask

  task automatic ack();
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  task automatic run(input string nm, input logic [2:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int lat, rh;
    issue(op, w, a, b, 5'(n_chk));
    wait_done(lat, rh);
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_res"}, result_o, exp);
    ack();
  endtask

  initial begin
    int lat, rh, bad;
    logic [63:0] held;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    op_i = 3'd0; word_i = 1'b0; op_a_i = '0; op_b_i = '0; tag_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // MUL 3*5 with tag, ready_o low while busy, then 10 cycles of backpressure
    issue(3'd0, 1'b0, 64'd3, 64'd5, 5'd17);
    wait_done(lat, rh);
    chk("mul_lat", 64'(lat), 64'd4);
    chk("mul_res", result_o, 64'd15);
    chk("mul_tag", 64'(tag_o), 64'd17);
    chk("mul_busy_rdy", 64'(rh), 64'd0);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (result_o !== 64'd15 || tag_o !== 5'd17 || !valid_o || ready_o) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    ack();
    chk("post_ack_rdy", 64'(ready_o), 64'd1);

    run("mulh",   3'd1, 1'b0, '1, '1, 64'd0, 4);
    run("mulhu",  3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 4);
    run("mulhsu", 3'd2, 1'b0, '1, 64'd2, '1, 4);
    run("div",    3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem",    3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65);
    run("divu",   3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run("remu",   3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    run("div0",   3'd4, 1'b0, 64'd100, 64'd0, '1, 1);
    run("rem0",   3'd6, 1'b0, 64'd100, 64'd0, 64'd100, 1);
    run("divovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run("removf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);

    // flush mid-divide: no result, result_o held, next request accepted at once
    held = result_o;
    issue(3'd4, 1'b0, 64'd1000, 64'd3, 5'd9);
    repeat (20) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_rdy", 64'(ready_o), 64'd1);
    chk("flush_valid", 64'(valid_o), 64'd0);
    chk("flush_res_held", result_o, held);
    issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd3);
    wait_done(lat, rh);
    chk("postflush_lat", 64'(lat), 64'd4);
    chk("postflush_res", result_o, 64'd42);
    chk("postflush_tag", 64'(tag_o), 64'd3);
    ack();

`ifdef MULDIV_WORD_OPS_EN
    run("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
    run("divuw",    3'd5, 1'b1, 64'h1_0000_0064, 64'd10, 64'd10, 33);
    run("remw",     3'd6, 1'b1, 64'h5_FFFF_FFF9, 64'd2, '1, 33);
    run("mulw",     3'd0, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 4);
    run("mulhu_w",  3'd3, 1'b1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
